// File: rtl/csla_pipe.sv
// csla_pipe: pipelined carry-select adder/subtractor with valid/ready on both sides.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand beat handshake (in_ready is a combinational chain)
//   a, b, cin, sub      operands; sub=1 computes a + ~b + 1 and ignores cin
//   out_valid/out_ready result handshake; result holds while stalled
//   sum, cout           WIDTH-bit result and carry out (in sub mode 1 = no borrow)
//   zero, ovf           result flags, only when CSLA_FLAGS_EN is defined; else tied 0
//
// Build option: define CSLA_FLAGS_EN to register zero/ovf alongside the final stage.
//
// Stage k handles SEG = BLOCK*BLOCKS_PER_STAGE bits. Its lowest slice ripples the
// registered carry directly; the remaining slices compute both carry variants
// (RCA with cin=0, then a binary-to-excess-1 converter) and select by the carry.
module csla_pipe #(
    parameter int unsigned WIDTH            = 64,
    parameter int unsigned BLOCK            = 4,
    parameter int unsigned BLOCKS_PER_STAGE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned SEG    = BLOCK * BLOCKS_PER_STAGE;
    localparam int unsigned STAGES = WIDTH / SEG;

    // Ripple-carry slice: returns {carry, sum}.
    function automatic logic [BLOCK:0] rca(input logic [BLOCK-1:0] x,
                                           input logic [BLOCK-1:0] y,
                                           input logic             ci);
        logic             c;
        logic [BLOCK-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Binary-to-excess-1: turns the cin=0 result into the cin=1 result.
    function automatic logic [BLOCK:0] bec(input logic [BLOCK:0] r);
        logic           t;
        logic [BLOCK:0] o;
        t = 1'b1;
        o = '0;
        for (int i = 0; i < BLOCK; i++) begin
            o[i] = r[i] ^ t;
            t    = t & r[i];
        end
        o[BLOCK] = r[BLOCK] | t;
        return o;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_src;
    logic [STAGES:0]   ready;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        ready         = '0;
        ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = ~v_q[k] | ready[k+1];
        end
    end

    always_comb begin
        v_src    = '0;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) v_q[k] <= v_src[k];
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned LO = k * SEG;
        localparam int unsigned HI = LO + SEG;

        // Operand bits [WIDTH-1:LO]; the low SEG bits belong to this stage.
        logic [WIDTH-LO-1:0] op_a;
        logic [WIDTH-LO-1:0] op_b;
        logic                c_in;
        logic [SEG-1:0]      seg_s;
        logic                seg_c;
        logic [HI-1:0]       sum_d;
        logic [HI-1:0]       sum_q;
        logic                c_q;
        logic                load;

        if (k == 0) begin : g_in
            assign op_a  = a;
            assign op_b  = sub ? ~b : b;
            assign c_in  = sub | cin;
            assign sum_d = seg_s;
        end else begin : g_in
            assign op_a  = g_st[k-1].g_ops.a_q;
            assign op_b  = g_st[k-1].g_ops.b_q;
            assign c_in  = g_st[k-1].c_q;
            assign sum_d = {seg_s, g_st[k-1].sum_q};
        end

        always_comb begin
            logic           carry;
            logic [BLOCK:0] r0;
            logic [BLOCK:0] r1;
            carry = c_in;
            seg_s = '0;
            r0    = '0;
            r1    = '0;
            for (int j = 0; j < BLOCKS_PER_STAGE; j++) begin
                if (j == 0) begin
                    r0 = rca(op_a[j*BLOCK +: BLOCK], op_b[j*BLOCK +: BLOCK], carry);
                    {carry, seg_s[j*BLOCK +: BLOCK]} = r0;
                end else begin
                    r0 = rca(op_a[j*BLOCK +: BLOCK], op_b[j*BLOCK +: BLOCK], 1'b0);
                    r1 = bec(r0);
                    {carry, seg_s[j*BLOCK +: BLOCK]} = carry ? r1 : r0;
                end
            end
            seg_c = carry;
        end

        // Data only moves with a valid beat, so an emitted result stays put until replaced.
        assign load = ready[k] & v_src[k];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (load) begin
                sum_q <= sum_d;
                c_q   <= seg_c;
            end
        end

        if (HI < WIDTH) begin : g_ops
            logic [WIDTH-HI-1:0] a_q;
            logic [WIDTH-HI-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= op_a[WIDTH-LO-1:SEG];
                    b_q <= op_b[WIDTH-LO-1:SEG];
                end
            end
        end
    end

    assign sum  = g_st[STAGES-1].sum_q;
    assign cout = g_st[STAGES-1].c_q;

`ifdef CSLA_FLAGS_EN
    localparam int unsigned LAST = STAGES - 1;

    logic zero_q;
    logic ovf_q;

    // Final-stage operand slice holds the operand MSBs (b already inverted for sub).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (ready[LAST] & v_src[LAST]) begin
            zero_q <= (g_st[LAST].sum_d == '0);
            ovf_q  <= (g_st[LAST].op_a[SEG-1] == g_st[LAST].op_b[SEG-1]) &
                      (g_st[LAST].seg_s[SEG-1] != g_st[LAST].op_a[SEG-1]);
        end
    end

    assign zero = zero_q;
    assign ovf  = ovf_q;
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_csla_pipe.sv
// tb_csla_pipe: randomized and directed bench for csla_pipe (WIDTH=64, 4 stages).
// A queue of expected results, computed with plain 65-bit arithmetic at accept time,
// is compared against every result the DUT presents.
module tb_csla_pipe;

    localparam int W      = 64;
    localparam int STAGES = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;

    csla_pipe #(
        .WIDTH           (64),
        .BLOCK           (4),
        .BLOCKS_PER_STAGE(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .zero     (zero),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         z;
        logic         o;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   emit_cyc[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    bit   lat_exact = 1'b1;
    bit   rand_rdy  = 1'b0;

`ifdef CSLA_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tc, input logic ts, input int acc);
        exp_t         e;
        logic [W-1:0] bp;
        logic [W:0]   r;
        bp    = ts ? ~tb_ : tb_;
        r     = {1'b0, ta} + {1'b0, bp} + {{W{1'b0}}, (ts ? 1'b1 : tc)};
        e.s   = r[W-1:0];
        e.c   = r[W];
        e.z   = FLAGS && (r[W-1:0] == '0);
        e.o   = FLAGS && (ta[W-1] == bp[W-1]) && (r[W-1] != ta[W-1]);
        e.acc = acc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always begin
        @(posedge clk);
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Compare process: inputs are stable at the falling edge and reflect the next transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 65'(out_valid), 65'(0));
                end else begin
                    chk("sum", {1'b0, sum}, {1'b0, exp_q[0].s});
                    chk("cout", 65'(cout), 65'(exp_q[0].c));
                    chk("zero", 65'(zero), 65'(exp_q[0].z));
                    chk("ovf", 65'(ovf), 65'(exp_q[0].o));
                    if (out_ready) begin
                        if (lat_exact) chk("latency", 65'(cyc - exp_q[0].acc), 65'(STAGES));
                        void'(exp_q.pop_front());
                        emit_cyc.push_back(cyc);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub, cyc));
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc, input logic ts);
        int n;
        n        = 0;
        a        = ta;
        b        = tb_;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_wait", 65'(in_ready), 65'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_lit(input string nm, input logic [W-1:0] s, input logic c,
                              input logic z, input logic o);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, 65'(out_valid), 65'(1));
        chk({nm, "_sum"}, {1'b0, sum}, {1'b0, s});
        chk({nm, "_cout"}, 65'(cout), 65'(c));
        chk({nm, "_zero"}, 65'(zero), 65'(FLAGS & z));
        chk({nm, "_ovf"}, 65'(ovf), 65'(FLAGS & o));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 65'(exp_q.size()), 65'(0));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_out_valid"}, 65'(out_valid), 65'(0));
        chk({nm, "_sum"}, {1'b0, sum}, 65'(0));
        chk({nm, "_cout"}, 65'(cout), 65'(0));
        chk({nm, "_flags"}, {63'(0), zero, ovf}, 65'(0));
        chk({nm, "_in_ready"}, 65'(in_ready), 65'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        int base;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        exp_t pin;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        #3;
        chk_reset_outputs("reset");
        #19;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pin the model to hand-computed values.
        pin = model(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0, 1'b1, 0);
        chk("model_sub", {pin.c, pin.s}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        pin = model(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0);
        chk("model_wrap", {pin.c, pin.s}, {1'b1, 64'h0});

        // Directed literal cases.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        expect_lit("wrap", 64'h0, 1'b1, 1'b1, 1'b0);
        send(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1, 1'b1);
        expect_lit("sub5m7", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        expect_lit("ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
        send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
        expect_lit("sub_eq", 64'h0, 1'b1, 1'b1, 1'b0);
        drain();

        // Back-to-back beats, full throughput.
        emit_cyc.delete();
        for (int i = 1; i <= 8; i++) begin
            send(64'(i) * 64'h0101_0101_0101_0101, 64'(i), 1'b0, 1'b0);
        end
        drain();
        chk("b2b_count", 65'(emit_cyc.size()), 65'(8));
        if (emit_cyc.size() == 8) chk("b2b_consecutive", 65'(emit_cyc[7] - emit_cyc[0]), 65'(7));

        // Downstream stall: pipe fills after four beats, results hold.
        lat_exact = 1'b0;
        out_ready = 1'b0;
        j         = 0;
        for (int t = 0; t < 10; t++) begin
            in_valid = (j < 6);
            a        = 64'hF000_0000_0000_0000 + 64'(j);
            b        = 64'(j) * 64'd3;
            cin      = 1'b0;
            sub      = j[0];
            @(negedge clk);
            if (in_valid && in_ready) j++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stall_accepts", 65'(j), 65'(4));
        chk("stall_in_ready", 65'(in_ready), 65'(0));
        base      = emit_cyc.size();
        out_ready = 1'b1;
        while (j < 6) begin
            send(64'hF000_0000_0000_0000 + 64'(j), 64'(j) * 64'd3, 1'b0, j[0]);
            j++;
        end
        drain();
        chk("stall_emitted", 65'(emit_cyc.size() - base), 65'(6));

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = ra;
                2: rb = '0;
                3: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            send(ra, rb, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with beats in flight.
        lat_exact = 1'b1;
        send(64'h1111, 64'h2222, 1'b0, 1'b0);
        send(64'h3333, 64'h4444, 1'b1, 1'b0);
        send(64'h5555, 64'h6666, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
        end
        chk("post_rst_idle", 65'(out_valid), 65'(0));
        send(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
        expect_lit("post_rst", 64'hDEAD_BEEF_FFFF_FFFF + 64'h2, 1'b0, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csla_pipe.md
Name: csla_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor; next generation of the team's 64-bit combinational CSLA.
- Operand width, slice width and pipeline depth are configurable. An add/subtract mode is added.
- valid/ready handshakes on both sides with per-stage bubble collapse, so the block drops into streaming datapaths.

Parameters:
WIDTH, 64, operand/sum width in bits; must be a multiple of BLOCK*BLOCKS_PER_STAGE
BLOCK, 4, slice width; each slice is an RCA(cin=0) + BEC + 2:1 mux
BLOCKS_PER_STAGE, 4, slices evaluated per pipeline stage; STAGES = WIDTH/(BLOCK*BLOCKS_PER_STAGE)

Ports:
clk  input  1  clock, all flops rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  1: a-b (a + ~b + 1); 0: a+b+cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB; in sub mode, 1 = no borrow
zero  output  1  sum == 0 (CSLA_FLAGS_EN only; else 0)
ovf  output  1  signed overflow (CSLA_FLAGS_EN only; else 0)

Behaviour:
- Reset (async, rst=1): every stage valid = 0, every data/carry register = 0. Outputs: out_valid=0, sum=0, cout=0, zero=0, ovf=0. in_ready reflects the empty pipe (1) while in reset. In-flight beats are discarded without output.
- Stage k (1..STAGES) owns bits [k*SEG-1:(k-1)*SEG], where SEG = BLOCK*BLOCKS_PER_STAGE.
  - Lowest slice of the stage is a plain ripple adder fed by the registered carry from stage k-1.
  - Stage 1's carry-in is cin, or 1 when sub=1.
  - Remaining slices are carry-select: RCA with cin=0, BEC to form the +1 variant, slice sum and carry muxed by the incoming carry.
- Stage registers carry forward:
  - sum bits already produced;
  - the carry;
  - upper operand bits not yet consumed, with b already inverted if sub;
  - the operand MSBs needed for ovf.
- Latency: exactly STAGES cycles from an accepted beat (in_valid & in_ready) to out_valid, with no stalls. Throughput is 1 beat/cycle.
- Handshake:
  - ready_STAGES = out_ready | ~v_STAGES; ready_k = ~v_k | ready_{k+1}; in_ready = ready_1 (combinational chain).
  - Stage k loads from stage k-1 when ready_k. Its valid becomes the upstream valid (in_valid for stage 1).
- Output holding: while out_valid & ~out_ready, sum/cout/flags hold stable. Upstream bubbles collapse into free stages.
- Beats are never dropped, duplicated or reordered. Results emerge in acceptance order.
- Arithmetic: {cout,sum} = a + b + cin, or a + ~b + 1 when sub=1, modulo 2^(WIDTH+1).
  - Wrap-around at all-ones is exact.
  - sub with a==b gives sum=0, cout=1.
- Simultaneous accept and emit in the same cycle is legal when full and out_ready=1.

Optional Feature:
Macro CSLA_FLAGS_EN.
- Defined: zero and ovf are registered alongside the final stage.
  - zero = (sum==0).
  - ovf = (A[MSB]==B'[MSB]) & (sum[MSB]!=A[MSB]), where B' is the post-inversion operand.
  - Both are reset to 0 and held with sum during stalls.
- Undefined: zero and ovf are tied to 0 and no flag logic or registers are generated. Timing and latency are otherwise identical.

Test Plan:
All scenarios use WIDTH=64, BLOCK=4, BLOCKS_PER_STAGE=4 (STAGES=4).
1. a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 -> 4 cycles later: sum=0, cout=1; zero=1 if CSLA_FLAGS_EN.
2. a=0000_0000_0000_0005, b=0000_0000_0000_0007, sub=1 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0.
3. a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=8000_0000_0000_0000, cout=0; ovf=1 if CSLA_FLAGS_EN.
4. Back-to-back beats 1..8, with a=i*0x0101_0101_0101_0101, b=i, out_ready=1 -> 8 consecutive out_valid cycles starting cycle 4, in order, every sum exact.
5. Stream 6 beats with out_ready=0 for 10 cycles: in_ready drops after 4 accepts; sum holds stable. Then out_ready=1 -> all 6 results emitted in order, none lost.
6. rst pulsed mid-stream with 3 beats in flight -> out_valid=0 and sum=0 immediately (async); no stale beats appear after release; next accepted beat emerges 4 cycles later.
